// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main controller:
// states, opcodes, aluop codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_BNEEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_IMMWB   = 4'd11,
        S_ORIEX   = 4'd12,
        S_JEX     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_OR    = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b100;
    localparam logic [2:0] ALUOP_BEQ   = 3'b110;
    localparam logic [2:0] ALUOP_BNE   = 3'b111;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: state register, next-state
// logic and combinational output decode with memory-ready stalls.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_d;
    logic   ill_d;
    logic   pcwrite, branch, branchn;
    logic   irw_raw, mw_raw, rw_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        ill_d   = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BNE:       state_d = S_BNEEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d = S_FETCH;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_IMMWB;
            S_ORIEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        iord     = 1'b0;
        irw_raw  = 1'b0;
        mw_raw   = 1'b0;
        rw_raw   = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_REGB;
        pcsrc    = PCSRC_ALU;
        aluop    = ALUOP_ADD;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        branchn  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                irw_raw = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                rw_raw   = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                iord   = 1'b1;
                mw_raw = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_RTYPE;
            end
            S_RTYPEWB: begin
                rw_raw = 1'b1;
                regdst = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_BEQ;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_BNEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_BNE;
                pcsrc   = PCSRC_ALUOUT;
                branchn = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_OR;
            end
            S_IMMWB: rw_raw = 1'b1;
            S_JEX: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so nothing fires while it is held low.
    assign irwrite  = irw_raw & reset;
    assign memwrite = mw_raw & reset;
    assign regwrite = rw_raw & reset;
    assign illegal  = ill_d & reset;
    assign pcen     = reset & (pcwrite | (branch & zero)
                               | (branchn & ~zero));
    assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed per-cycle vectors
// queued by the driver, compared by a monitor on the falling edge.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg;
    logic       alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;
    logic [3:0] state;

    typedef struct {
        int          id;
        logic [20:0] vec;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   nstep  = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .irwrite(irwrite),
        .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen),
        .illegal(illegal), .state(state)
    );

    // {state, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
    //  alusrca, alusrcb, pcsrc, aluop, pcen, illegal}
    function automatic logic [20:0] ex(
        input logic [3:0] st, input logic io, input logic irw,
        input logic mw, input logic rw, input logic rd,
        input logic m2r, input logic asa, input logic [1:0] asb,
        input logic [1:0] pcs, input logic [2:0] aop,
        input logic pe, input logic ill);
        return {st, io, irw, mw, rw, rd, m2r, asa, asb, pcs, aop,
                pe, ill};
    endfunction

    logic [20:0] F_GO, F_STALL, D_OK, D_ILL, MADR, MRD, MWB, MWR;
    logic [20:0] REX, RWB, BEQ1, BEQ0, BNE1, BNE0, AEX, IWB, OEX, JX;

    initial begin
        F_GO    = ex(4'd0,  0,1,0,0,0,0,0,2'b01,2'b00,3'b000,1,0);
        F_STALL = ex(4'd0,  0,0,0,0,0,0,0,2'b01,2'b00,3'b000,0,0);
        D_OK    = ex(4'd1,  0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0,0);
        D_ILL   = ex(4'd1,  0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0,1);
        MADR    = ex(4'd2,  0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0,0);
        MRD     = ex(4'd3,  1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
        MWB     = ex(4'd4,  0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,0);
        MWR     = ex(4'd5,  1,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,0);
        REX     = ex(4'd6,  0,0,0,0,0,0,1,2'b00,2'b00,3'b100,0,0);
        RWB     = ex(4'd7,  0,0,0,1,1,0,0,2'b00,2'b00,3'b000,0,0);
        BEQ1    = ex(4'd8,  0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1,0);
        BEQ0    = ex(4'd8,  0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0);
        BNE1    = ex(4'd9,  0,0,0,0,0,0,1,2'b00,2'b01,3'b111,1,0);
        BNE0    = ex(4'd9,  0,0,0,0,0,0,1,2'b00,2'b01,3'b111,0,0);
        AEX     = ex(4'd10, 0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0,0);
        IWB     = ex(4'd11, 0,0,0,1,0,0,0,2'b00,2'b00,3'b000,0,0);
        OEX     = ex(4'd12, 0,0,0,0,0,0,1,2'b10,2'b00,3'b001,0,0);
        JX      = ex(4'd13, 0,0,0,0,0,0,0,2'b00,2'b10,3'b000,1,0);
    end

    task automatic step(input logic rst, input logic [5:0] o,
                        input logic z, input logic mr,
                        input logic [20:0] e);
        exp_t t;
        @(posedge clk);
        #1;
        reset     = rst;
        op        = o;
        zero      = z;
        mem_ready = mr;
        t.id  = nstep;
        t.vec = e;
        sb.push_back(t);
        nstep++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        t;
            logic [20:0] act;
            t   = sb.pop_front();
            act = {state, iord, irwrite, memwrite, regwrite, regdst,
                   memtoreg, alusrca, alusrcb, pcsrc, aluop, pcen,
                   illegal};
            checks++;
            if (act === t.vec) passes++;
            else $display("FAIL step%0d outputs: got %h want %h",
                          t.id, act, t.vec);
        end
    end

    initial begin
        reset = 1'b0; op = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        // reset held low
        step(0, 6'b100011, 0, 1, F_STALL);
        step(0, 6'b100011, 0, 1, F_STALL);
        // lw, no stalls
        step(1, 6'b100011, 0, 1, F_GO);
        step(1, 6'b100011, 0, 1, D_OK);
        step(1, 6'b100011, 0, 1, MADR);
        step(1, 6'b100011, 0, 1, MRD);
        step(1, 6'b100011, 0, 1, MWB);
        // lw with fetch and read stalls
        step(1, 6'b100011, 0, 0, F_STALL);
        step(1, 6'b100011, 0, 1, F_GO);
        step(1, 6'b100011, 0, 1, D_OK);
        step(1, 6'b100011, 0, 1, MADR);
        step(1, 6'b100011, 0, 0, MRD);
        step(1, 6'b100011, 0, 1, MRD);
        step(1, 6'b100011, 0, 1, MWB);
        // sw with three stalled write cycles
        step(1, 6'b101011, 0, 1, F_GO);
        step(1, 6'b101011, 0, 1, D_OK);
        step(1, 6'b101011, 0, 1, MADR);
        step(1, 6'b101011, 0, 0, MWR);
        step(1, 6'b101011, 0, 0, MWR);
        step(1, 6'b101011, 0, 0, MWR);
        step(1, 6'b101011, 0, 1, MWR);
        // beq taken / not taken
        step(1, 6'b000100, 1, 1, F_GO);
        step(1, 6'b000100, 1, 1, D_OK);
        step(1, 6'b000100, 1, 1, BEQ1);
        step(1, 6'b000100, 0, 1, F_GO);
        step(1, 6'b000100, 0, 1, D_OK);
        step(1, 6'b000100, 0, 1, BEQ0);
        // bne with zero=1 then zero=0
        step(1, 6'b000101, 1, 1, F_GO);
        step(1, 6'b000101, 1, 1, D_OK);
        step(1, 6'b000101, 1, 1, BNE0);
        step(1, 6'b000101, 0, 1, F_GO);
        step(1, 6'b000101, 0, 1, D_OK);
        step(1, 6'b000101, 0, 1, BNE1);
        // ori, addi, R-type, j
        step(1, 6'b001101, 0, 1, F_GO);
        step(1, 6'b001101, 0, 1, D_OK);
        step(1, 6'b001101, 0, 1, OEX);
        step(1, 6'b001101, 0, 1, IWB);
        step(1, 6'b001000, 0, 1, F_GO);
        step(1, 6'b001000, 0, 1, D_OK);
        step(1, 6'b001000, 0, 1, AEX);
        step(1, 6'b001000, 1, 1, IWB);
        step(1, 6'b000000, 0, 1, F_GO);
        step(1, 6'b000000, 0, 1, D_OK);
        step(1, 6'b000000, 0, 1, REX);
        step(1, 6'b000000, 0, 1, RWB);
        step(1, 6'b000010, 0, 1, F_GO);
        step(1, 6'b000010, 0, 1, D_OK);
        step(1, 6'b000010, 0, 1, JX);
        // illegal opcode
        step(1, 6'b111111, 0, 1, F_GO);
        step(1, 6'b111111, 0, 1, D_ILL);
        step(1, 6'b111111, 0, 1, F_GO);
        step(1, 6'b111111, 0, 1, D_ILL);
        // async reset while in MEMWB of lw, then release
        step(1, 6'b100011, 0, 1, F_GO);
        step(1, 6'b100011, 0, 1, D_OK);
        step(1, 6'b100011, 0, 1, MADR);
        step(1, 6'b100011, 0, 1, MRD);
        step(0, 6'b100011, 0, 1, F_STALL);
        step(1, 6'b100011, 0, 1, F_GO);
        step(1, 6'b100011, 0, 1, D_OK);

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
